tdc_multi_accum: RTL and testbench

// - Multi-channel TDC back end. Captures N_CH delay-line thermometer words and synchronises them.
// - Takes the Hamming weight of each channel and accumulates 2**LOG_SAMPLES samples per channel.
// - Drains the per-channel sums over a valid/ready stream.
// - Sits between the delay lines and the readout/scan logic; all logic runs on one clock.

---
 rtl/tdc_multi_accum.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_tdc_multi_accum.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_multi_accum.sv
// Multi-channel TDC back end: tap capture/sync, per-channel popcount, sample accumulation, result drain.
// Optional macro TDC_MINMAX_EN adds per-channel minimum/maximum sample weight tracking.
module tdc_multi_accum #(
    parameter int N           = 64,
    parameter int N_CH        = 2,
    parameter int LOG_SAMPLES = 4,
    parameter int N_SYNC      = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            en_i,
    input  logic                            start_i,
    input  logic [N_CH*N-1:0]               dl_in_i,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [$clog2(N_CH):0]           out_ch_o,
    output logic [$clog2(N)+LOG_SAMPLES:0]  out_sum_o
`ifdef TDC_MINMAX_EN
    ,
    output logic [$clog2(N):0]              out_min_o,
    output logic [$clog2(N):0]              out_max_o
`endif
);

    localparam int PCW = $clog2(N) + 1;
    localparam int SW  = PCW + LOG_SAMPLES;
    localparam int CHW = $clog2(N_CH) + 1;
    localparam int FCW = $clog2(N_SYNC + 1) + 1;
    localparam int SCW = LOG_SAMPLES + 1;

    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(N_SYNC);
    localparam logic [SCW-1:0] SAMP_LAST  = SCW'((1 << LOG_SAMPLES) - 1);
    localparam logic [CHW-1:0] CH_LAST    = CHW'(N_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        ACCUM = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic logic [PCW-1:0] popcount(input logic [N-1:0] w);
        logic [PCW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{(PCW-1){1'b0}}, w[i]};
        end
        return cnt;
    endfunction

    state_t           state_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [CHW-1:0]   ch_q;
    logic [FCW-1:0]   flush_cnt_q;
    logic [SCW-1:0]   samp_cnt_q;
    logic [SW-1:0]    out_sum_q;

    logic [N_CH*N-1:0] sync_q [N_SYNC];
    logic [PCW-1:0]    pc_q   [N_CH];
    logic [SW-1:0]     sum_q  [N_CH];
    logic [SW-1:0]     sum_d  [N_CH];

    logic             clear_s;
    logic             acc_s;
    logic [CHW-1:0]   ch_sel_s;
    logic [SW-1:0]    out_sum_nx_s;

`ifdef TDC_MINMAX_EN
    logic [PCW-1:0]   min_q [N_CH];
    logic [PCW-1:0]   max_q [N_CH];
    logic [PCW-1:0]   min_d [N_CH];
    logic [PCW-1:0]   max_d [N_CH];
    logic [PCW-1:0]   out_min_q;
    logic [PCW-1:0]   out_max_q;
    logic [PCW-1:0]   out_min_nx_s;
    logic [PCW-1:0]   out_max_nx_s;
`endif

    // Capture and synchronise the raw taps; runs regardless of FSM state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= dl_in_i;
            for (int i = 1; i < N_SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Registered Hamming weight of each synchronised channel.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                pc_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                pc_q[c] <= popcount(sync_q[N_SYNC-1][c*N +: N]);
            end
        end
    end

    // Accumulator next state: cleared on the FLUSH->ACCUM step, summed on enabled ACCUM cycles.
    always_comb begin
        clear_s = (state_q == FLUSH) && en_i && (flush_cnt_q == FLUSH_LAST);
        acc_s   = (state_q == ACCUM) && en_i;
        for (int c = 0; c < N_CH; c++) begin
            if (clear_s) begin
                sum_d[c] = '0;
            end else if (acc_s) begin
                sum_d[c] = sum_q[c] + {{LOG_SAMPLES{1'b0}}, pc_q[c]};
            end else begin
                sum_d[c] = sum_q[c];
            end
        end
    end

`ifdef TDC_MINMAX_EN
    // Min/max next state with strict comparisons; min starts at all-ones so a zero sample wins.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            if (clear_s) begin
                min_d[c] = '1;
                max_d[c] = '0;
            end else if (acc_s) begin
                min_d[c] = (pc_q[c] < min_q[c]) ? pc_q[c] : min_q[c];
                max_d[c] = (pc_q[c] > max_q[c]) ? pc_q[c] : max_q[c];
            end else begin
                min_d[c] = min_q[c];
                max_d[c] = max_q[c];
            end
        end
    end

    // Per-channel min/max storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                min_q[c] <= '0;
                max_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                min_q[c] <= min_d[c];
                max_q[c] <= max_d[c];
            end
        end
    end
`endif

    // Per-channel sum storage.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int c = 0; c < N_CH; c++) begin
                sum_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                sum_q[c] <= sum_d[c];
            end
        end
    end

    // Select the channel to present next: 0 when entering DRAIN, ch_q+1 while draining.
    always_comb begin
        if (state_q == DRAIN) begin
            ch_sel_s = ch_q + {{(CHW-1){1'b0}}, 1'b1};
        end else begin
            ch_sel_s = '0;
        end
        out_sum_nx_s = '0;
`ifdef TDC_MINMAX_EN
        out_min_nx_s = '0;
        out_max_nx_s = '0;
`endif
        for (int c = 0; c < N_CH; c++) begin
            if (CHW'(c) == ch_sel_s) begin
                out_sum_nx_s = sum_d[c];
`ifdef TDC_MINMAX_EN
                out_min_nx_s = min_d[c];
                out_max_nx_s = max_d[c];
`endif
            end else begin
                out_sum_nx_s = out_sum_nx_s;
            end
        end
    end

    // Measurement FSM with registered status and result outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            ch_q        <= '0;
            flush_cnt_q <= '0;
            samp_cnt_q  <= '0;
            out_sum_q   <= '0;
`ifdef TDC_MINMAX_EN
            out_min_q   <= '0;
            out_max_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && en_i) begin
                        state_q     <= FLUSH;
                        busy_q      <= 1'b1;
                        flush_cnt_q <= '0;
                    end
                end
                FLUSH: begin
                    if (en_i) begin
                        if (flush_cnt_q == FLUSH_LAST) begin
                            state_q    <= ACCUM;
                            samp_cnt_q <= '0;
                        end else begin
                            flush_cnt_q <= flush_cnt_q + {{(FCW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ACCUM: begin
                    if (en_i) begin
                        if (samp_cnt_q == SAMP_LAST) begin
                            state_q   <= DRAIN;
                            valid_q   <= 1'b1;
                            ch_q      <= '0;
                            out_sum_q <= out_sum_nx_s;
`ifdef TDC_MINMAX_EN
                            out_min_q <= out_min_nx_s;
                            out_max_q <= out_max_nx_s;
`endif
                        end else begin
                            samp_cnt_q <= samp_cnt_q + {{(SCW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (ch_q == CH_LAST) begin
                            state_q <= IDLE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            ch_q    <= '0;
                        end else begin
                            ch_q      <= ch_sel_s;
                            out_sum_q <= out_sum_nx_s;
`ifdef TDC_MINMAX_EN
                            out_min_q <= out_min_nx_s;
                            out_max_q <= out_max_nx_s;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign out_valid_o = valid_q;
    assign out_ch_o    = ch_q;
    assign out_sum_o   = out_sum_q;
`ifdef TDC_MINMAX_EN
    assign out_min_o   = out_min_q;
    assign out_max_o   = out_max_q;
`endif

endmodule

// File: tb/tb_tdc_multi_accum.sv
// Scoreboard bench for tdc_multi_accum: directed scenarios plus randomized measurements.
module tb_tdc_multi_accum;

    localparam int N    = 64;
    localparam int N_CH = 2;
    localparam int LS   = 2;
    localparam int NS   = 2;
    localparam int PCW  = $clog2(N) + 1;
    localparam int SW   = PCW + LS;
    localparam int CHW  = $clog2(N_CH) + 1;
    localparam int NSAMP = 1 << LS;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               en_i;
    logic               start_i;
    logic [N_CH*N-1:0]  dl_in_i;
    logic               busy_o;
    logic               done_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [CHW-1:0]     out_ch_o;
    logic [SW-1:0]      out_sum_o;
`ifdef TDC_MINMAX_EN
    logic [PCW-1:0]     out_min_o;
    logic [PCW-1:0]     out_max_o;
`endif

    typedef struct {
        int ch;
        int sum;
        int mn;
        int mx;
    } exp_t;

    exp_t           exp_q[$];
    exp_t           mon_e;
    int             n_checks = 0;
    int             n_fail   = 0;
    int             done_cnt = 0;
    int             exp_done = 0;
    bit             hold_r   = 1'b0;
    bit             prev_done = 1'b0;
    logic [CHW-1:0] held_ch;
    logic [SW-1:0]  held_sum;
    int             bc;

    tdc_multi_accum #(
        .N(N), .N_CH(N_CH), .LOG_SAMPLES(LS), .N_SYNC(NS)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .start_i     (start_i),
        .dl_in_i     (dl_in_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_ch_o    (out_ch_o),
        .out_sum_o   (out_sum_o)
`ifdef TDC_MINMAX_EN
        ,
        .out_min_o   (out_min_o),
        .out_max_o   (out_max_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [N-1:0] therm(input int k);
        logic [N-1:0] w;
        w = '0;
        for (int i = 0; i < k; i++) w[i] = 1'b1;
        return w;
    endfunction

    function automatic logic [N-1:0] rand_word();
        int mode;
        mode = int'($urandom_range(0, 3));
        case (mode)
            0:       return '0;
            1:       return '1;
            2:       return {$urandom(), $urandom()};
            default: return therm(int'($urandom_range(0, N)));
        endcase
    endfunction

    // Expected results for a measurement with each channel held constant.
    task automatic push_const(input logic [N-1:0] w0, input logic [N-1:0] w1);
        exp_t e;
        e.ch = 0; e.sum = $countones(w0) * NSAMP; e.mn = $countones(w0); e.mx = $countones(w0);
        exp_q.push_back(e);
        e.ch = 1; e.sum = $countones(w1) * NSAMP; e.mn = $countones(w1); e.mx = $countones(w1);
        exp_q.push_back(e);
    endtask

    // Result monitor: pops the scoreboard on each transfer, checks stability while stalled.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            hold_r    = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (hold_r) begin
                check("hold_valid", longint'(out_valid_o), 1);
                check("hold_ch", longint'(out_ch_o), longint'(held_ch));
                check("hold_sum", longint'(out_sum_o), longint'(held_sum));
            end
            if (done_o) begin
                done_cnt++;
                if (prev_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_width: done high on consecutive cycles, expected 1-cycle pulse");
                end
            end
            prev_done = done_o;
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: ch %0d sum %0d presented, none expected", out_ch_o, out_sum_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_ch", longint'(out_ch_o), longint'(mon_e.ch));
                    check("out_sum", longint'(out_sum_o), longint'(mon_e.sum));
`ifdef TDC_MINMAX_EN
                    check("out_min", longint'(out_min_o), longint'(mon_e.mn));
                    check("out_max", longint'(out_max_o), longint'(mon_e.mx));
`endif
                end
            end
            hold_r   = out_valid_o && !out_ready_i;
            held_ch  = out_ch_o;
            held_sum = out_sum_o;
        end
    end

    // One measurement: pulse start, optional en gap / ready gap / random flow control, wait for done.
    task automatic run_meas(input logic [N-1:0] w0, input logic [N-1:0] w1, input bit rnd,
                            input int en_gap, input int rdy_gap, input bit alt,
                            input logic [N-1:0] w0b, output int busy_cycles);
        bit fin;
        dl_in_i     = {w1, w0};
        start_i     = 1'b1;
        en_i        = 1'b1;
        out_ready_i = 1'b1;
        exp_done++;
        busy_cycles = 0;
        fin         = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            @(posedge clk_i);
            #1;
            if (rnd) begin
                start_i     = ($urandom_range(0, 7) == 0);
                en_i        = ($urandom_range(0, 3) != 0);
                out_ready_i = ($urandom_range(0, 2) != 0);
            end else begin
                start_i     = 1'b0;
                en_i        = !(k >= en_gap && k < en_gap + 3);
                out_ready_i = !(k >= rdy_gap && k < rdy_gap + 5);
            end
            if (alt) dl_in_i[N-1:0] = (k % 2 == 0) ? w0b : w0;
            @(negedge clk_i);
            if (busy_o) busy_cycles++;
            if (done_o) begin
                fin     = 1'b1;
                start_i = 1'b0;
                check("busy_after_done", longint'(busy_o), 0);
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL meas_timeout: done not seen within 400 cycles, busy=%0d", busy_o);
        end
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        en_i        = 1'b1;
        out_ready_i = 1'b1;
    endtask

    initial begin
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        start_i     = 1'b0;
        out_ready_i = 1'b0;
        dl_in_i     = '1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_done", longint'(done_o), 0);
        check("rst_valid", longint'(out_valid_o), 0);
        check("rst_ch", longint'(out_ch_o), 0);
        check("rst_sum", longint'(out_sum_o), 0);
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b1;
        dl_in_i = '0;
        repeat (2) @(posedge clk_i);
        #1;

        // Baseline: 20 and 64 ones.
        push_const(therm(20), '1);
        run_meas(therm(20), '1, 1'b0, 999, 999, 1'b0, '0, bc);
        check("busy_len_basic", bc, (NS + 1) + NSAMP + N_CH);

        // Consumer stalls for 5 cycles at the start of DRAIN.
        push_const(therm(20), '1);
        run_meas(therm(20), '1, 1'b0, 999, 7, 1'b0, '0, bc);
        check("busy_len_stall", bc, (NS + 1) + NSAMP + N_CH + 5);

        // en low for 3 cycles inside ACCUM.
        push_const(therm(20), '1);
        run_meas(therm(20), '1, 1'b0, 4, 999, 1'b0, '0, bc);
        check("busy_len_pause", bc, (NS + 1) + NSAMP + N_CH + 3);

        // Abort by reset in ACCUM, with a second start while busy.
        dl_in_i = {{N{1'b1}}, therm(5)};
        start_i = 1'b1;
        en_i    = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        @(posedge clk_i); #1; start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("abort_busy", longint'(busy_o), 0);
        check("abort_done", longint'(done_o), 0);
        check("abort_valid", longint'(out_valid_o), 0);
        check("abort_ch", longint'(out_ch_o), 0);
        check("abort_sum", longint'(out_sum_o), 0);
`ifdef TDC_MINMAX_EN
        check("abort_min", longint'(out_min_o), 0);
        check("abort_max", longint'(out_max_o), 0);
`endif
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        push_const(therm(20), '1);
        run_meas(therm(20), '1, 1'b0, 999, 999, 1'b0, '0, bc);

        // Alternating 30/10 ones on ch0, ch1 idle.
        begin
            exp_t e;
            e.ch = 0; e.sum = (NSAMP / 2) * 30 + (NSAMP / 2) * 10; e.mn = 10; e.mx = 30;
            exp_q.push_back(e);
            e.ch = 1; e.sum = 0; e.mn = 0; e.mx = 0;
            exp_q.push_back(e);
        end
        run_meas(therm(30), '0, 1'b0, 999, 999, 1'b1, therm(10), bc);

        // All-zero taps.
        dl_in_i = '1;
        @(posedge clk_i);
        #1;
        push_const('0, '0);
        run_meas('0, '0, 1'b0, 999, 999, 1'b0, '0, bc);

        // Randomized measurements with random en, ready and stray starts.
        for (int it = 0; it < 25; it++) begin
            logic [N-1:0] r0;
            logic [N-1:0] r1;
            dl_in_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            en_i    = ($urandom_range(0, 1) != 0);
            repeat (2) @(posedge clk_i);
            #1;
            r0 = rand_word();
            r1 = rand_word();
            push_const(r0, r1);
            run_meas(r0, r1, 1'b1, 999, 999, 1'b0, '0, bc);
        end

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("done_pulses", done_cnt, exp_done);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
